fadd_tree_sched: RTL and testbench
==================================

FADD_TREE_SCHED -- requirements
Module: fadd_tree_sched

Interface
REQ-001 Parameter: REQ_NUM, default 4, number of requesters sharing one fadd_tree.
REQ-002 Parameter: MAC_NUM, default 8, lanes per beat; must match the tree's MAC_NUM.
REQ-003 Parameter: DATA_BIT, default 16, bfloat16 word width.
REQ-004 Parameter: TREE_LAT, default 4, tree input-to-output latency in cycles ($clog2(MAC_NUM)+1).
REQ-005 Parameter: ID_BIT, default $clog2(REQ_NUM), requester id width.
REQ-006 Port: clk  in  1  single clock; all logic samples on the rising edge.
REQ-007 Port: rst  in  1  synchronous, active-high reset.
REQ-008 Port: req_valid  in  REQ_NUM  per-requester beat valid.
REQ-009 Port: req_data  in  REQ_NUM*MAC_NUM*DATA_BIT  per-requester lane data; requester i occupies slice i.
REQ-010 Port: req_mask  in  REQ_NUM*MAC_NUM  per-requester lane enables.
REQ-011 Port: req_last  in  REQ_NUM  final beat of the requester's burst.
REQ-012 Port: req_ready  out  REQ_NUM  beat accepted when req_valid[i] and req_ready[i] are both high.
REQ-013 Port: tree_idata  out  MAC_NUM*DATA_BIT  data to the tree.
REQ-014 Port: tree_idata_valid  out  MAC_NUM  lane valids to the tree.
REQ-015 Port: tree_last_in  out  1  last flag to the tree.
REQ-016 Port: tree_odata  in  DATA_BIT  tree sum.
REQ-017 Port: tree_odata_valid  in  1  tree sum valid.
REQ-018 Port: tree_last_out  in  1  tree last flag.
REQ-019 Port: rsp_data  out  DATA_BIT  sum returned to a requester.
REQ-020 Port: rsp_valid  out  1  response valid; no backpressure.
REQ-021 Port: rsp_id  out  ID_BIT  owner of the response.
REQ-022 Port: rsp_last  out  1  last sum of the burst.
REQ-023 Port: err  out  1  sticky tag/tree mismatch flag.

Function
REQ-024 FSM states: IDLE and BURST.
- IDLE -> BURST when any req_valid is high; the grant is latched into gnt_id.
- BURST -> IDLE on the cycle after an accepted beat with req_last high.
REQ-025 Arbitration is round-robin.
- The search starts at ptr and wraps modulo REQ_NUM.
- ptr <= gnt_id+1 (mod REQ_NUM) on each grant.
REQ-026 Grant lock: req_ready[i] = (state==BURST && gnt_id==i); all other requesters are stalled for the whole burst.
REQ-027 Beat issue is combinational from the granted requester:
- tree_idata = req_data[gnt_id]
- tree_idata_valid = req_mask[gnt_id] gated by an accepted beat
- tree_last_in = req_last[gnt_id] gated by an accepted beat
REQ-028 Zero-mask beat: when the accepted beat's req_mask is all zero, lane 0 is driven as valid with data 0x0000, so the tree still emits one result (+0).
REQ-029 No beat is issued in IDLE; tree_idata_valid=0 and tree_last_in=0 there.
REQ-030 Tag pipeline: a TREE_LAT-deep shift register of {valid, id, last}.
- One entry is pushed per accepted beat; an empty entry is pushed otherwise.
REQ-031 Response timing: rsp_valid, rsp_data, rsp_id and rsp_last follow tree_odata_valid, tree_odata, the tag id and tree_last_out combinationally.
- The response appears exactly TREE_LAT cycles after the beat is accepted.
REQ-032 Mismatch: err is set if tree_odata_valid differs from the tag valid, or if tree_last_out differs from the tag last.
- err stays set until rst.
- rsp_valid is suppressed when the tag valid is 0.
REQ-033 A requester dropping req_valid mid-burst holds the grant; no timeout; no beat is issued.
REQ-034 Back-to-back bursts from different requesters are separated by exactly one IDLE cycle.

Reset
REQ-035 When rst=1 on a clock edge, the following are cleared, and all outputs are 0 on the next cycle:
- state=IDLE, ptr=0, gnt_id=0
- all tag entries invalid
- err=0
REQ-036 The tree shall be reset by the same rst (inverted for its rstn) so in-flight sums are flushed together with the tags.
REQ-037 rst asserted mid-burst aborts the burst; the requester re-arbitrates after rst deasserts.

Verification
REQ-038 Requester 0, one beat of 8 lanes at 0x3F80 with mask 0xFF and req_last=1 -> rsp_valid=1, rsp_data=0x4100, rsp_id=0, rsp_last=1 exactly TREE_LAT cycles after the beat is accepted.
REQ-039 Requesters 1 and 3 both request from reset (ptr=0) -> 1 is granted first; after its last beat plus one IDLE cycle, 3 is granted; the next grant search starts at 0.
REQ-040 Requester 2 sends a 3-beat burst with masks 0x0F, 0x00, 0xFF, each lane 0x3F80 -> responses 0x4080, 0x0000, 0x4100 with rsp_id=2, and rsp_last only on the third.
REQ-041 Requester 0 drops req_valid for 5 cycles mid-burst while requester 1 is pending -> req_ready[1] stays 0, no tree_idata_valid is asserted, and the burst resumes.
REQ-042 rst pulsed for 1 cycle while 2 beats are in flight -> no rsp_valid from those beats, err=0, and state=IDLE.
REQ-043 A tree model with latency TREE_LAT+1 -> err=1 on the first response, and it stays set.

Source files
------------

// File: rtl/fadd_tree_sched.sv
// Round-robin scheduler that time-shares one fadd_tree between REQ_NUM requesters, one burst at a time.
// Latency: beat issue is combinational; the response returns TREE_LAT cycles after the beat is accepted.
// Backpressure: only the granted requester sees req_ready during its burst; responses cannot be stalled.
module fadd_tree_sched #(
    parameter int REQ_NUM  = 4,
    parameter int MAC_NUM  = 8,
    parameter int DATA_BIT = 16,
    parameter int TREE_LAT = 4,
    parameter int ID_BIT   = $clog2(REQ_NUM)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [REQ_NUM-1:0]                   req_valid,
    input  logic [REQ_NUM*MAC_NUM*DATA_BIT-1:0]  req_data,
    input  logic [REQ_NUM*MAC_NUM-1:0]           req_mask,
    input  logic [REQ_NUM-1:0]                   req_last,
    output logic [REQ_NUM-1:0]                   req_ready,
    output logic [MAC_NUM*DATA_BIT-1:0]          tree_idata,
    output logic [MAC_NUM-1:0]                   tree_idata_valid,
    output logic                                 tree_last_in,
    input  logic [DATA_BIT-1:0]                  tree_odata,
    input  logic                                 tree_odata_valid,
    input  logic                                 tree_last_out,
    output logic [DATA_BIT-1:0]                  rsp_data,
    output logic                                 rsp_valid,
    output logic [ID_BIT-1:0]                    rsp_id,
    output logic                                 rsp_last,
    output logic                                 err
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [ID_BIT-1:0]          r_gnt_id;
    logic [ID_BIT-1:0]          r_ptr;
    logic                       r_err;
    logic                       r_tag_vld  [TREE_LAT];
    logic [ID_BIT-1:0]          r_tag_id   [TREE_LAT];
    logic                       r_tag_last [TREE_LAT];

    logic                       w_arb_found;
    logic [ID_BIT-1:0]          w_arb_id;
    logic                       w_accept;
    logic                       w_gnt_last;
    logic [MAC_NUM-1:0]         w_gnt_mask;
    logic [MAC_NUM*DATA_BIT-1:0] w_gnt_data;
    logic                       w_tag_vld;
    logic [ID_BIT-1:0]          w_tag_id;
    logic                       w_tag_last;

    assign w_gnt_data = req_data[int'(r_gnt_id)*MAC_NUM*DATA_BIT +: MAC_NUM*DATA_BIT];
    assign w_gnt_mask = req_mask[int'(r_gnt_id)*MAC_NUM +: MAC_NUM];
    assign w_gnt_last = req_last[r_gnt_id];
    // A beat moves only while the granted requester presents valid; a dropped valid just idles the burst.
    assign w_accept   = (r_state == S_BURST) && req_valid[r_gnt_id];

    // Round-robin search from r_ptr; walking offsets downward lets the smallest offset win.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_id    = '0;
        for (int k = REQ_NUM - 1; k >= 0; k--) begin
            if (req_valid[(int'(r_ptr) + k) % REQ_NUM]) begin
                w_arb_found = 1'b1;
                w_arb_id    = ID_BIT'((int'(r_ptr) + k) % REQ_NUM);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: grant from IDLE, return to IDLE once the last beat is accepted.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_arb_found) w_state_nxt = S_BURST;
            S_BURST: if (w_accept && w_gnt_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Latch the grant and advance the round-robin pointer past the winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt_id <= '0;
            r_ptr    <= '0;
        end else if (r_state == S_IDLE && w_arb_found) begin
            r_gnt_id <= w_arb_id;
            r_ptr    <= ID_BIT'((int'(w_arb_id) + 1) % REQ_NUM);
        end
    end

    // Grant lock: only the owner of the burst is ever ready.
    always_comb begin
        req_ready = '0;
        if (r_state == S_BURST) req_ready[r_gnt_id] = 1'b1;
    end

    // Beat issue; an all-zero mask still sends +0 on lane 0 so the tree returns one sum per beat.
    always_comb begin
        tree_idata       = '0;
        tree_idata_valid = '0;
        tree_last_in     = 1'b0;
        if (w_accept) begin
            tree_last_in = w_gnt_last;
            if (w_gnt_mask == '0) begin
                tree_idata_valid = MAC_NUM'(1);
            end else begin
                tree_idata       = w_gnt_data;
                tree_idata_valid = w_gnt_mask;
            end
        end
    end

    // Tag shift register tracking each beat through the tree; bubbles are pushed as empty entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TREE_LAT; i++) begin
                r_tag_vld[i]  <= 1'b0;
                r_tag_id[i]   <= '0;
                r_tag_last[i] <= 1'b0;
            end
        end else begin
            r_tag_vld[0]  <= w_accept;
            r_tag_id[0]   <= w_accept ? r_gnt_id : '0;
            r_tag_last[0] <= w_accept && w_gnt_last;
            for (int i = 1; i < TREE_LAT; i++) begin
                r_tag_vld[i]  <= r_tag_vld[i-1];
                r_tag_id[i]   <= r_tag_id[i-1];
                r_tag_last[i] <= r_tag_last[i-1];
            end
        end
    end

    assign w_tag_vld  = r_tag_vld[TREE_LAT-1];
    assign w_tag_id   = r_tag_id[TREE_LAT-1];
    assign w_tag_last = r_tag_last[TREE_LAT-1];

    // Sticky flag whenever the tree's valid/last disagree with the tag that should line up with them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((tree_odata_valid != w_tag_vld) || (tree_last_out != w_tag_last)) begin
            r_err <= 1'b1;
        end
    end

    assign err       = r_err;
    assign rsp_valid = tree_odata_valid && w_tag_vld;
    assign rsp_data  = rsp_valid ? tree_odata : '0;
    assign rsp_id    = w_tag_id;
    assign rsp_last  = tree_last_out && w_tag_vld;

endmodule

// File: tb/tb_fadd_tree_sched.sv
// Directed bench for fadd_tree_sched with a behavioural adder-tree model of selectable latency.
// Latency: tree model returns the lane sum TREE_LAT (or TREE_LAT+1) cycles after a beat.
// Backpressure: none; inputs are driven between clock edges and outputs checked before the next edge.
module tb_fadd_tree_sched;
    localparam int REQ_NUM  = 4;
    localparam int MAC_NUM  = 8;
    localparam int DATA_BIT = 16;
    localparam int TREE_LAT = 4;
    localparam int ID_BIT   = 2;

    logic                                clk = 1'b0;
    logic                                rst;
    logic [REQ_NUM-1:0]                  req_valid;
    logic [REQ_NUM*MAC_NUM*DATA_BIT-1:0] req_data;
    logic [REQ_NUM*MAC_NUM-1:0]          req_mask;
    logic [REQ_NUM-1:0]                  req_last;
    logic [REQ_NUM-1:0]                  req_ready;
    logic [MAC_NUM*DATA_BIT-1:0]         tree_idata;
    logic [MAC_NUM-1:0]                  tree_idata_valid;
    logic                                tree_last_in;
    logic [DATA_BIT-1:0]                 tree_odata;
    logic                                tree_odata_valid;
    logic                                tree_last_out;
    logic [DATA_BIT-1:0]                 rsp_data;
    logic                                rsp_valid;
    logic [ID_BIT-1:0]                   rsp_id;
    logic                                rsp_last;
    logic                                err;

    int n_tests = 0;
    int n_fail  = 0;
    int tree_lat = TREE_LAT;

    fadd_tree_sched #(
        .REQ_NUM(REQ_NUM), .MAC_NUM(MAC_NUM), .DATA_BIT(DATA_BIT),
        .TREE_LAT(TREE_LAT), .ID_BIT(ID_BIT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_mask(req_mask), .req_last(req_last),
        .req_ready(req_ready),
        .tree_idata(tree_idata), .tree_idata_valid(tree_idata_valid), .tree_last_in(tree_last_in),
        .tree_odata(tree_odata), .tree_odata_valid(tree_odata_valid), .tree_last_out(tree_last_out),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_last(rsp_last),
        .err(err)
    );

    always #5 clk = ~clk;

    // Integer-valued bfloat16 helpers, enough for sums of 1.0 lanes.
    function automatic int bf2int(input logic [15:0] b);
        int v;
        int sh;
        if (b[14:0] == 15'd0) return 0;
        v  = int'({1'b1, b[6:0]});
        sh = int'(b[14:7]) - 127 - 7;
        return (sh >= 0) ? (v << sh) : (v >> (-sh));
    endfunction

    function automatic logic [15:0] int2bf(input int s);
        int p;
        int m;
        logic [7:0] e;
        if (s == 0) return 16'h0000;
        p = 0;
        for (int i = 0; i < 31; i++) if (s >= (1 << i)) p = i;
        m = (p >= 7) ? (s >> (p - 7)) : (s << (7 - p));
        e = 8'(127 + p);
        return {1'b0, e, m[6:0]};
    endfunction

    function automatic logic [15:0] lane_sum(input logic [MAC_NUM*DATA_BIT-1:0] d,
                                             input logic [MAC_NUM-1:0] v);
        int s;
        s = 0;
        for (int j = 0; j < MAC_NUM; j++) if (v[j]) s += bf2int(d[j*DATA_BIT +: DATA_BIT]);
        return int2bf(s);
    endfunction

    // Behavioural tree: delay line flushed by the shared reset, output tap picked by tree_lat.
    logic        tm_v [TREE_LAT+1];
    logic [15:0] tm_d [TREE_LAT+1];
    logic        tm_l [TREE_LAT+1];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= TREE_LAT; i++) begin
                tm_v[i] <= 1'b0; tm_d[i] <= 16'h0; tm_l[i] <= 1'b0;
            end
        end else begin
            tm_v[0] <= |tree_idata_valid;
            tm_d[0] <= lane_sum(tree_idata, tree_idata_valid);
            tm_l[0] <= tree_last_in;
            for (int i = 1; i <= TREE_LAT; i++) begin
                tm_v[i] <= tm_v[i-1]; tm_d[i] <= tm_d[i-1]; tm_l[i] <= tm_l[i-1];
            end
        end
    end

    assign tree_odata_valid = tm_v[tree_lat-1];
    assign tree_odata       = tm_d[tree_lat-1];
    assign tree_last_out    = tm_l[tree_lat-1];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic [7:0] m, input logic l);
        req_valid[r]           = v;
        req_mask[r*MAC_NUM +: MAC_NUM] = m;
        req_last[r]            = l;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_mask  = '0;
        req_last  = '0;
        for (int j = 0; j < REQ_NUM*MAC_NUM; j++) req_data[j*DATA_BIT +: DATA_BIT] = 16'h3F80;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_ready", 128'(req_ready), 0);
        chk("rst_tree_vld", 128'(tree_idata_valid), 0);
        chk("rst_rsp_vld", 128'(rsp_valid), 0);
        chk("rst_err", 128'(err), 0);

        // Single 8-lane beat from requester 0.
        set_req(0, 1'b1, 8'hFF, 1'b1);
        #1 chk("t1_idle_ready", 128'(req_ready), 0);
        tick();
        chk("t1_ready", 128'(req_ready), 128'h1);
        chk("t1_tree_vld", 128'(tree_idata_valid), 128'hFF);
        chk("t1_tree_last", 128'(tree_last_in), 1);
        tick();
        set_req(0, 1'b0, 8'h00, 1'b0);
        repeat (TREE_LAT - 2) tick();
        chk("t1_rsp_early", 128'(rsp_valid), 0);
        tick();
        chk("t1_rsp_vld", 128'(rsp_valid), 1);
        chk("t1_rsp_data", 128'(rsp_data), 128'h4100);
        chk("t1_rsp_id", 128'(rsp_id), 0);
        chk("t1_rsp_last", 128'(rsp_last), 1);
        chk("t1_err", 128'(err), 0);
        tick();

        // Reset to bring ptr back to 0, then requesters 1 and 3 contend.
        rst = 1'b1; tick(); rst = 1'b0;
        set_req(1, 1'b1, 8'hFF, 1'b1);
        set_req(3, 1'b1, 8'hFF, 1'b1);
        tick();
        chk("t2_gnt1", 128'(req_ready), 128'h2);
        tick();
        set_req(1, 1'b0, 8'h00, 1'b0);
        #1 chk("t2_idle_gap", 128'(req_ready), 0);
        tick();
        chk("t2_gnt3", 128'(req_ready), 128'h8);
        tick();
        set_req(3, 1'b0, 8'h00, 1'b0);
        tick();
        chk("t2_rsp1_vld", 128'(rsp_valid), 1);
        chk("t2_rsp1_id", 128'(rsp_id), 1);
        tick();
        chk("t2_rsp_gap", 128'(rsp_valid), 0);
        tick();
        chk("t2_rsp3_vld", 128'(rsp_valid), 1);
        chk("t2_rsp3_id", 128'(rsp_id), 3);
        // Pointer wrapped to 0: requester 0 beats requester 2.
        set_req(0, 1'b1, 8'hFF, 1'b1);
        set_req(2, 1'b1, 8'hFF, 1'b1);
        tick();
        chk("t2_wrap_gnt0", 128'(req_ready), 128'h1);
        tick();
        set_req(0, 1'b0, 8'h00, 1'b0);
        tick();
        chk("t2_then_gnt2", 128'(req_ready), 128'h4);
        tick();
        set_req(2, 1'b0, 8'h00, 1'b0);
        repeat (TREE_LAT + 2) tick();

        // Three-beat burst from requester 2 with masks 0F, 00, FF.
        set_req(2, 1'b1, 8'h0F, 1'b0);
        tick();
        chk("t3_ready", 128'(req_ready), 128'h4);
        chk("t3_b1_vld", 128'(tree_idata_valid), 128'h0F);
        tick();
        set_req(2, 1'b1, 8'h00, 1'b0);
        #1;
        chk("t3_b2_vld", 128'(tree_idata_valid), 128'h01);
        chk("t3_b2_lane0", 128'(tree_idata[15:0]), 0);
        tick();
        set_req(2, 1'b1, 8'hFF, 1'b1);
        #1 chk("t3_b3_last", 128'(tree_last_in), 1);
        tick();
        set_req(2, 1'b0, 8'h00, 1'b0);
        tick();
        chk("t3_r1", 128'({rsp_valid, rsp_last, rsp_id, rsp_data}), 128'({1'b1, 1'b0, 2'd2, 16'h4080}));
        tick();
        chk("t3_r2", 128'({rsp_valid, rsp_last, rsp_id, rsp_data}), 128'({1'b1, 1'b0, 2'd2, 16'h0000}));
        tick();
        chk("t3_r3", 128'({rsp_valid, rsp_last, rsp_id, rsp_data}), 128'({1'b1, 1'b1, 2'd2, 16'h4100}));
        tick();
        chk("t3_r_end", 128'(rsp_valid), 0);

        // Requester 0 stalls mid-burst while requester 1 waits.
        set_req(0, 1'b1, 8'hFF, 1'b0);
        set_req(1, 1'b1, 8'hFF, 1'b1);
        tick();
        chk("t4_gnt0", 128'(req_ready), 128'h1);
        tick();
        set_req(0, 1'b0, 8'hFF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_hold_ready", 128'(req_ready), 128'h1);
            chk("t4_no_beat", 128'(tree_idata_valid), 0);
            tick();
        end
        set_req(0, 1'b1, 8'hFF, 1'b1);
        #1 chk("t4_resume", 128'(tree_idata_valid), 128'hFF);
        tick();
        set_req(0, 1'b0, 8'h00, 1'b0);
        tick();
        chk("t4_gnt1", 128'(req_ready), 128'h2);
        tick();
        set_req(1, 1'b0, 8'h00, 1'b0);
        repeat (TREE_LAT + 2) tick();
        chk("t4_err", 128'(err), 0);

        // Reset lands while two beats of a burst are in flight.
        set_req(2, 1'b1, 8'hFF, 1'b0);
        tick();
        chk("t5_gnt2", 128'(req_ready), 128'h4);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(2, 1'b0, 8'h00, 1'b0);
        #1 chk("t5_idle", 128'(req_ready), 0);
        for (int i = 0; i < TREE_LAT + 1; i++) begin
            chk("t5_no_rsp", 128'(rsp_valid), 0);
            tick();
        end
        chk("t5_err", 128'(err), 0);
        set_req(2, 1'b1, 8'hFF, 1'b1);
        tick();
        chk("t5_regrant", 128'(req_ready), 128'h4);
        tick();
        set_req(2, 1'b0, 8'h00, 1'b0);
        repeat (TREE_LAT + 2) tick();

        // Tree one cycle slower than the tags expect.
        tree_lat = TREE_LAT + 1;
        set_req(0, 1'b1, 8'hFF, 1'b1);
        tick();
        tick();
        set_req(0, 1'b0, 8'h00, 1'b0);
        repeat (TREE_LAT) tick();
        chk("t6_err_set", 128'(err), 1);
        chk("t6_rsp_suppr", 128'(rsp_valid), 0);
        repeat (3) tick();
        chk("t6_err_sticky", 128'(err), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
